// File: rtl/boot_sequencer_pkg.sv
// boot_sequencer_pkg: shared state type and memory byte strides for the boot sequencer
package boot_sequencer_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_I, LOAD_D, RUN, DUMP_RD, DUMP_HOLD, DONE} state_t;
  localparam logic [63:0] IMEM_STRIDE = 64'd4;
  localparam logic [63:0] DMEM_STRIDE = 64'd8;
endpackage

// File: rtl/boot_sequencer_counter.sv
// seq_counter: loadable down-counter that holds at zero; tc flags the last remaining count
module seq_counter #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] value,
  output logic [W-1:0] count,
  output logic         tc
);
  always_ff @(posedge clk)
    if (!arst_n) count <= '0;
    else if (load) count <= value;
    else if (dec && count != '0) count <= count - 1'b1;
  assign tc = count == W'(1);
endmodule

// File: rtl/boot_sequencer.sv
// boot_sequencer: streams imem/dmem images in, runs the CPU for a fixed time, then streams dmem out
module boot_sequencer
  import boot_sequencer_pkg::*;
#(
  parameter int IMEM_DEPTH = 512,
  parameter int DMEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        start,
  input  logic [9:0]  imem_len,
  input  logic [10:0] dmem_len,
  input  logic [31:0] run_cycles,
  input  logic [10:0] dump_len,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        cpu_enable,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  input  logic [63:0] rdata_ext_2,
  output logic        busy,
  output logic        done
);
  state_t state;
  logic [10:0] il, dl, ul, il_c, dl_c, ul_c, wc, wc_val, k;
  logic [31:0] rc, cc;
  logic wc_tc, cc_tc, wc_load, wc_dec, cc_load, xfer, ack, i_end, d_end, r_end, hold_first;
  // wc counts remaining words of the current phase; k is the index of the word in flight
  always_comb begin
    il_c = 11'(imem_len) > 11'(IMEM_DEPTH) ? 11'(IMEM_DEPTH) : 11'(imem_len);
    dl_c = dmem_len > 11'(DMEM_DEPTH) ? 11'(DMEM_DEPTH) : dmem_len;
    ul_c = dump_len > 11'(DMEM_DEPTH) ? 11'(DMEM_DEPTH) : dump_len;
    in_ready = arst_n && ((state == LOAD_I && il != '0) || (state == LOAD_D && dl != '0));
    xfer = in_valid && in_ready;
    ack = state == DUMP_HOLD && out_valid && out_ready;
    i_end = il == '0 || (xfer && wc_tc);
    d_end = dl == '0 || (xfer && wc_tc);
    r_end = cc == '0 || cc_tc;
    wc_load = (state == IDLE && start) || (state == LOAD_I && i_end) || (state == LOAD_D && d_end);
    wc_val = state == IDLE ? il_c : state == LOAD_I ? dl : ul;
    wc_dec = xfer || ack;
    cc_load = state == LOAD_D && d_end;
    k = (state == LOAD_I ? il : state == LOAD_D ? dl : ul) - wc;
    wen_ext = state == LOAD_I && xfer;
    wdata_ext = wen_ext ? in_data[31:0] : '0;
    addr_ext = wen_ext ? 64'(k) * IMEM_STRIDE : '0;
    wen_ext_2 = state == LOAD_D && xfer;
    ren_ext_2 = arst_n && state == DUMP_RD && ul != '0;
    wdata_ext_2 = wen_ext_2 ? in_data : '0;
    addr_ext_2 = (wen_ext_2 || ren_ext_2) ? 64'(k) * DMEM_STRIDE : '0;
    ren_ext = 1'b0;
    cpu_enable = arst_n && state == RUN && cc != '0;
    busy = state != IDLE;
    done = state == DONE;
  end
  seq_counter #(.W(11)) u_wc (
    .clk(clk), .arst_n(arst_n), .load(wc_load), .dec(wc_dec), .value(wc_val), .count(wc), .tc(wc_tc)
  );
  seq_counter #(.W(32)) u_cc (
    .clk(clk), .arst_n(arst_n), .load(cc_load), .dec(state == RUN), .value(rc), .count(cc), .tc(cc_tc)
  );
  // read data lands one cycle after DUMP_RD, so the first DUMP_HOLD cycle captures it
  always_ff @(posedge clk)
    if (!arst_n) begin
      state <= IDLE;
      il <= '0;
      dl <= '0;
      ul <= '0;
      rc <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      hold_first <= 1'b0;
    end else
      case (state)
        IDLE: if (start) begin
          il <= il_c;
          dl <= dl_c;
          ul <= ul_c;
          rc <= run_cycles;
          state <= LOAD_I;
        end
        LOAD_I: if (i_end) state <= LOAD_D;
        LOAD_D: if (d_end) state <= RUN;
        RUN: if (r_end) state <= DUMP_RD;
        DUMP_RD: begin
          state <= ul == '0 ? DONE : DUMP_HOLD;
          hold_first <= 1'b1;
        end
        DUMP_HOLD: if (hold_first) begin
          out_data <= rdata_ext_2;
          out_valid <= 1'b1;
          hold_first <= 1'b0;
        end else if (out_ready) begin
          out_valid <= 1'b0;
          state <= wc_tc ? DONE : DUMP_RD;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_boot_sequencer.sv
// tb_boot_sequencer: directed checks of load, run, dump, zero-length, clamp and reset behaviour
module tb_boot_sequencer;
  logic clk = 0, arst_n = 0, start = 0, in_valid = 0, out_ready = 0;
  logic [9:0] imem_len = 0;
  logic [10:0] dmem_len = 0, dump_len = 0;
  logic [31:0] run_cycles = 0;
  logic [63:0] in_data = 0, rdata_ext_2 = 0;
  logic in_ready, out_valid, cpu_enable, wen_ext, ren_ext, wen_ext_2, ren_ext_2, busy, done;
  logic [63:0] out_data, addr_ext, addr_ext_2, wdata_ext_2;
  logic [31:0] wdata_ext;
  logic [63:0] dmem [1024];
  logic [63:0] ia_q[$], id_q[$], da_q[$], dd_q[$];
  logic [63:0] w [5];
  int passed = 0, total = 0;
  int en_cnt = 0, en_runs = 0, rd_cnt = 0, done_cnt = 0, rdy_cnt = 0, bad_cnt = 0;
  logic prev_en = 0;

  boot_sequencer dut (
    .clk(clk), .arst_n(arst_n), .start(start), .imem_len(imem_len), .dmem_len(dmem_len),
    .run_cycles(run_cycles), .dump_len(dump_len), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cpu_enable(cpu_enable), .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
    .wdata_ext(wdata_ext), .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wen_ext_2) dmem[addr_ext_2[12:3]] <= wdata_ext_2;
    if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[12:3]];
  end

  always @(negedge clk) begin
    if (wen_ext) begin ia_q.push_back(addr_ext); id_q.push_back(64'(wdata_ext)); end
    if (wen_ext_2) begin da_q.push_back(addr_ext_2); dd_q.push_back(wdata_ext_2); end
    if (cpu_enable) en_cnt++;
    if (cpu_enable && !prev_en) en_runs++;
    if (ren_ext_2) rd_cnt++;
    if (done) done_cnt++;
    if (in_ready) rdy_cnt++;
    if (cpu_enable && (wen_ext || wen_ext_2 || ren_ext_2 || ren_ext)) bad_cnt++;
    prev_en = cpu_enable;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_hi(input int sel, input int lim, input string tag);
    int n = 0;
    logic hit = 0;
    while (!hit && n < lim) begin
      @(negedge clk);
      hit = sel == 0 ? out_valid : sel == 1 ? done : cpu_enable;
      n++;
    end
    chk(tag, 64'(hit), 64'd1);
  endtask

  task automatic go(input logic [9:0] il, input logic [10:0] dl, input logic [31:0] rc, input logic [10:0] ul);
    @(posedge clk); #1;
    imem_len = il; dmem_len = dl; run_cycles = rc; dump_len = ul; start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic accept();
    @(posedge clk); #1 out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
  endtask

  initial begin
    int idx, n, s_i, s_d, s_rd, s_en, s_rdy, s_done, s_runs;
    for (int i = 0; i < 5; i++) w[i] = 64'h0123_4567_89AB_0000 + 64'(i) * 64'h1_0001_0001;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", 64'({busy, done, in_ready, out_valid, cpu_enable, wen_ext, wen_ext_2, ren_ext_2, ren_ext}), 64'd0);
    chk("reset_out_data", out_data, 64'd0);
    chk("reset_addr", addr_ext | addr_ext_2, 64'd0);
    @(posedge clk); #1 arst_n = 1;

    // full sequence with random in_valid gaps
    go(3, 2, 5, 2);
    idx = 0; n = 0;
    while (idx < 5 && n < 300) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = w[idx];
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 0;
    chk("load_words", 64'(idx), 64'd5);
    wait_hi(0, 60, "first_out_valid");
    chk("imem_writes", 64'(ia_q.size()), 64'd3);
    chk("dmem_writes", 64'(da_q.size()), 64'd2);
    for (int i = 0; i < 3 && i < ia_q.size(); i++) begin
      chk("imem_addr", ia_q[i], 64'(i * 4));
      chk("imem_data", id_q[i], 64'(w[i][31:0]));
    end
    for (int i = 0; i < 2 && i < da_q.size(); i++) begin
      chk("dmem_addr", da_q[i], 64'(i * 8));
      chk("dmem_data", dd_q[i], w[3 + i]);
    end
    chk("cpu_en_cycles", 64'(en_cnt), 64'd5);
    chk("cpu_en_runs", 64'(en_runs), 64'd1);
    chk("mem_idle_in_run", 64'(bad_cnt), 64'd0);
    chk("dump0_data", out_data, w[3]);
    s_rd = rd_cnt;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_data", out_data, w[3]);
      chk("hold_no_read", 64'(rd_cnt - s_rd), 64'd0);
    end
    accept();
    wait_hi(0, 10, "second_out_valid");
    chk("dump1_data", out_data, w[4]);
    chk("dump1_reads", 64'(rd_cnt - s_rd), 64'd1);
    accept();
    wait_hi(1, 10, "done_seen");
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("done_count", 64'(done_cnt), 64'd1);

    // all-zero lengths with in_valid held high
    s_i = ia_q.size(); s_d = da_q.size(); s_rd = rd_cnt; s_en = en_cnt; s_rdy = rdy_cnt; s_done = done_cnt;
    in_valid = 1; in_data = 64'hFFFF_0000_FFFF_0000;
    go(0, 0, 0, 0);
    @(negedge clk);
    chk("zero_busy", 64'(busy), 64'd1);
    wait_hi(1, 20, "zero_done_seen");
    @(negedge clk);
    chk("zero_done_pulse", 64'(done), 64'd0);
    chk("zero_idle", 64'(busy), 64'd0);
    chk("zero_writes", 64'(ia_q.size() - s_i + da_q.size() - s_d), 64'd0);
    chk("zero_reads", 64'(rd_cnt - s_rd), 64'd0);
    chk("zero_cpu_en", 64'(en_cnt - s_en), 64'd0);
    chk("zero_in_ready", 64'(rdy_cnt - s_rdy), 64'd0);
    chk("zero_done_count", 64'(done_cnt - s_done), 64'd1);

    // oversize imem_len clamps to depth; a second start mid-load is ignored
    s_i = ia_q.size(); s_done = done_cnt;
    in_data = 64'h5555_AAAA_1234_5678;
    go(10'd1023, 0, 0, 0);
    repeat (10) @(posedge clk);
    #1 start = 1;
    @(posedge clk); #1 start = 0;
    wait_hi(1, 700, "clamp_done_seen");
    repeat (3) @(negedge clk);
    chk("clamp_idle", 64'(busy), 64'd0);
    chk("clamp_writes", 64'(ia_q.size() - s_i), 64'd512);
    chk("clamp_first_addr", ia_q[s_i], 64'h0);
    chk("clamp_last_addr", ia_q[$], 64'h7FC);
    chk("clamp_done_count", 64'(done_cnt - s_done), 64'd1);

    // reset during RUN, then a fresh sequence
    in_data = 64'hDEAD_BEEF_0123_4567; out_ready = 1;
    go(1, 1, 10, 1);
    wait_hi(2, 20, "run_entered");
    @(posedge clk); #1 arst_n = 0;
    s_i = ia_q.size(); s_d = da_q.size();
    @(negedge clk);
    @(negedge clk);
    chk("rst_cpu_en", 64'(cpu_enable), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ctrl", 64'({in_ready, out_valid, done, ren_ext_2}), 64'd0);
    @(posedge clk); #1 arst_n = 1;
    chk("rst_no_writes", 64'(ia_q.size() - s_i + da_q.size() - s_d), 64'd0);
    in_data = 64'h0BAD_F00D_CAFE_0042;
    s_en = en_cnt; s_runs = en_runs;
    go(1, 1, 2, 1);
    wait_hi(0, 30, "restart_out_valid");
    chk("restart_data", out_data, 64'h0BAD_F00D_CAFE_0042);
    wait_hi(1, 10, "restart_done_seen");
    chk("restart_cpu_en", 64'(en_cnt - s_en), 64'd2);
    chk("restart_runs", 64'(en_runs - s_runs), 64'd1);
    in_valid = 0; out_ready = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/boot_sequencer.md
BOOT_SEQUENCER -- requirements
Module: boot_sequencer

Interface
REQ-001 The block SHALL have parameter IMEM_DEPTH, default 512: instruction memory depth in 32-bit words.
REQ-002 The block SHALL have parameter DMEM_DEPTH, default 1024: data memory depth in 64-bit words.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port arst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: begin a load/run/dump sequence.
REQ-006 The block SHALL have ports imem_len (input, 10 bits) and dmem_len (input, 11 bits): words to load.
REQ-007 The block SHALL have port run_cycles, input, 32 bits: CPU enable duration in cycles.
REQ-008 The block SHALL have port dump_len, input, 11 bits: data words to read back.
REQ-009 The block SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, 64): load stream.
REQ-010 The block SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, 64): dump stream.
REQ-011 The block SHALL have port cpu_enable, output, 1 bit: drives the CPU enable.
REQ-012 The block SHALL have ports addr_ext (64), wen_ext (1), ren_ext (1) and wdata_ext (32), all outputs: instruction memory external port.
REQ-013 The block SHALL have ports addr_ext_2 (64), wen_ext_2 (1), ren_ext_2 (1) and wdata_ext_2 (64), all outputs, plus rdata_ext_2 (input, 64): data memory external port.
REQ-014 The block SHALL have ports busy and done, outputs, 1 bit each: status.

Function
REQ-015 The state machine SHALL have the states IDLE, LOAD_I, LOAD_D, RUN, DUMP_RD, DUMP_HOLD and DONE.
REQ-016 In IDLE, start=1 SHALL latch imem_len, dmem_len, run_cycles and dump_len, clamp each length to its depth, clear the word counter and enter LOAD_I; start outside IDLE SHALL be ignored.
REQ-017 in_ready SHALL be 1 only in LOAD_I and LOAD_D, and a word transfers on in_valid&in_ready.
REQ-018 In LOAD_I, each transfer SHALL assert wen_ext=1 in the same cycle with wdata_ext=in_data[31:0] and addr_ext=4*k, where k is the word counter (zero-extended).
REQ-019 In LOAD_D, each transfer SHALL assert wen_ext_2=1 with wdata_ext_2=in_data and addr_ext_2=8*k.
REQ-020 On the transfer of the last word, or on entry when the latched length is 0, the state SHALL advance to the next phase and reset k to 0.
REQ-021 In RUN, cpu_enable SHALL be 1 for exactly run_cycles consecutive cycles, and then the state SHALL enter DUMP_RD; run_cycles=0 SHALL skip RUN with cpu_enable never asserted.
REQ-022 cpu_enable SHALL be 0 in every state other than RUN, and the external memory ports SHALL be idle (all enables 0) during RUN.
REQ-023 DUMP_RD SHALL assert ren_ext_2=1 for one cycle with addr_ext_2=8*k and then enter DUMP_HOLD; data memory read latency is one cycle.
REQ-024 On entry to DUMP_HOLD, out_data SHALL be registered from rdata_ext_2 and out_valid=1 SHALL be held with out_data stable until out_ready=1.
REQ-025 When out_ready=1 in DUMP_HOLD, k SHALL increment and the state SHALL go to DUMP_RD, or to DONE after the last word; dump_len=0 SHALL go directly to DONE.
REQ-026 DONE SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 ren_ext SHALL be tied to 0, and the enables and data of an idle memory port SHALL be 0.
REQ-029 Counters SHALL be 11 bits for words and 32 bits for cycles; no counter SHALL wrap, because each terminates at its latched limit.

Reset
REQ-030 With arst_n=0 at a rising edge, the block SHALL enter IDLE and all outputs SHALL be 0 from the next cycle, including cpu_enable, in_ready, out_valid, busy, done, all memory enables and addresses, and out_data.
REQ-031 A reset mid-sequence SHALL abandon the sequence with no further memory writes, and memory contents SHALL NOT be restored.

Structure
REQ-032 A shared package SHALL hold the state enum type and the byte-stride constants (4 for instruction memory, 8 for data memory).
REQ-033 A single sub-module, seq_counter (loadable down-counter with terminal-count flag), SHALL be used for both the word counter and the cycle counter.

Verification
REQ-034 The bench SHALL drive imem_len=3, dmem_len=2, run_cycles=5, dump_len=2 with start, then stream 5 words, and SHALL check imem writes at 0x0/0x4/0x8, dmem writes at 0x0/0x8, and cpu_enable high exactly 5 cycles.
REQ-035 The bench SHALL hold out_ready=0 for 4 cycles on the first dump word and SHALL check that out_valid and out_data stay stable and that no second ren_ext_2 occurs until acceptance.
REQ-036 The bench SHALL drive imem_len=0, dmem_len=0, run_cycles=0, dump_len=0 and SHALL check IDLE, DONE (done=1 for one cycle) and IDLE with no memory or enable activity.
REQ-037 The bench SHALL drive imem_len=1023 and SHALL check that exactly 512 instruction writes occur, with the last at addr_ext=0x7FC.
REQ-038 The bench SHALL assert arst_n=0 during RUN at cycle 2 and SHALL check that cpu_enable=0 and busy=0 on the next cycle, and that start is accepted afterwards.
REQ-039 The bench SHALL toggle in_valid randomly during load and SHALL check that exactly one write occurs per handshake, with no gaps in the address sequence.
